// File: rtl/dplca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dplca_pkg
// Description : Shared constants for the D-PLCA node controller: FSM state
//               codes, PLCA command encodings and PLCA status encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package dplca_pkg;

    // ------------------------------------------------------------------------
    // FSM state codes (4-bit; codes 10..15 are illegal and recover to DISABLED)
    // ------------------------------------------------------------------------
    typedef logic [3:0] dplca_state_t;

    localparam dplca_state_t ST_DISABLED            = 4'd0;
    localparam dplca_state_t ST_WAIT_BEACON         = 4'd1;
    localparam dplca_state_t ST_COORDINATOR         = 4'd2;
    localparam dplca_state_t ST_REDUCE_NODE_COUNT   = 4'd3;
    localparam dplca_state_t ST_LOOPBACK_TX         = 4'd4;
    localparam dplca_state_t ST_LOOPBACK_RX         = 4'd5;
    localparam dplca_state_t ST_LEARNING            = 4'd6;
    localparam dplca_state_t ST_INCREASE_NODE_COUNT = 4'd7;
    localparam dplca_state_t ST_FOLLOWER            = 4'd8;
    localparam dplca_state_t ST_RANDOM_WAIT         = 4'd9;

    // ------------------------------------------------------------------------
    // PLCA command encodings carried on rx_cmd / tx_cmd
    // ------------------------------------------------------------------------
    typedef logic [1:0] plca_cmd_t;

    localparam plca_cmd_t CMD_BEACON = 2'b00;
    localparam plca_cmd_t CMD_COMMIT = 2'b01;
    localparam plca_cmd_t CMD_NONE   = 2'b10;

    // ------------------------------------------------------------------------
    // PLCA status encodings
    // ------------------------------------------------------------------------
    localparam logic STATUS_OK   = 1'b1;
    localparam logic STATUS_FAIL = 1'b0;

    // Next state of the 16-bit Fibonacci LFSR, taps 16,14,13,11 (shift left,
    // feedback enters at bit 0).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

endpackage : dplca_pkg
`default_nettype wire

// File: rtl/dplca_claim_scan.sv
`default_nettype none
// ============================================================================
// Module      : dplca_claim_scan
// Description : Combinational priority encoders over the TXOP claim table.
//               max_claim : highest set index in claim_table (0 if empty).
//               pick_free : lowest clear index in 1..node_count-1, or
//                           2**NODE_W-2 when every index in that range is
//                           claimed.
// Ports       : claim_table [2**NODE_W-1:0] in  - bit i set = TXOP i claimed
//               node_count  [NODE_W-1:0]    in  - current node count
//               max_claim   [NODE_W-1:0]    out - highest claimed index
//               pick_free   [NODE_W-1:0]    out - lowest free ID candidate
// Revision    : 1.0 - initial release
// ============================================================================
module dplca_claim_scan #(
    parameter int NODE_W = 8
) (
    input  logic [2**NODE_W-1:0] claim_table,
    input  logic [NODE_W-1:0]    node_count,
    output logic [NODE_W-1:0]    max_claim,
    output logic [NODE_W-1:0]    pick_free
);

    localparam int                c_table_size    = 2**NODE_W;
    localparam logic [NODE_W-1:0] c_unassigned_id = NODE_W'(2**NODE_W - 2);

    logic w_found;

    // Highest set bit: ascending scan, later hits overwrite earlier ones.
    always_comb begin
        max_claim = '0;
        for (int i = 0; i < c_table_size; i++) begin
            if (claim_table[i]) begin
                max_claim = NODE_W'(i);
            end
        end
    end

    // Lowest clear bit in 1..node_count-1. ID 0 is reserved for the
    // coordinator and therefore never offered.
    always_comb begin
        pick_free = c_unassigned_id;
        w_found   = 1'b0;
        for (int i = 1; i < c_table_size; i++) begin
            if (!w_found && (i < int'(node_count)) && !claim_table[i]) begin
                pick_free = NODE_W'(i);
                w_found   = 1'b1;
            end
        end
    end

endmodule : dplca_claim_scan
`default_nettype wire

// File: rtl/dplca_node_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dplca_node_ctrl
// Description : D-PLCA node controller. Decides whether this node acts as
//               PLCA coordinator or follower, learns a free node ID from the
//               TXOP claim table, and adapts plca_node_count while
//               coordinating.
// Ports       : clk                      in  - sole clock
//               plca_reset               in  - synchronous active-high reset
//               dplca_en, plca_en        in  - enables (both needed)
//               wait_beacon_timer_done   in  - external timer expired
//               coordinator_role_allowed in  - node may become coordinator
//               plca_status              in  - OK=1, FAIL=0
//               rx_cmd, tx_cmd           in  - BEACON=00, COMMIT=01, NONE=10
//               dplca_txop_table_upd     in  - claim-table update strobe
//               dplca_new_age            in  - new aging cycle
//               dplca_txop_id            in  - received TXOP ID
//               dplca_txop_node_count    in  - received TXOP node count
//               txop_claim_table         in  - bit i set = TXOP i claimed
//               wait_beacon_timer_start  out - one-cycle timer start pulse
//               dplca_aging              out - aging enable
//               local_nodeID             out - current local node ID
//               plca_node_count          out - current node count
//               mod_state                out - FSM state code
// Revision    : 1.0 - initial release
// ============================================================================
module dplca_node_ctrl #(
    parameter int          NODE_W         = 8,
    parameter int          MIN_NODE_COUNT = 8,
    parameter int          MAX_NODE_COUNT = 2**NODE_W - 1,
    parameter int          RAND_W         = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 plca_reset,
    input  logic                 dplca_en,
    input  logic                 plca_en,
    input  logic                 wait_beacon_timer_done,
    input  logic                 coordinator_role_allowed,
    input  logic                 plca_status,
    input  logic [1:0]           rx_cmd,
    input  logic [1:0]           tx_cmd,
    input  logic                 dplca_txop_table_upd,
    input  logic                 dplca_new_age,
    input  logic [NODE_W-1:0]    dplca_txop_id,
    input  logic [NODE_W-1:0]    dplca_txop_node_count,
    input  logic [2**NODE_W-1:0] txop_claim_table,
    output logic                 wait_beacon_timer_start,
    output logic                 dplca_aging,
    output logic [NODE_W-1:0]    local_nodeID,
    output logic [NODE_W-1:0]    plca_node_count,
    output logic [3:0]           mod_state
);

    import dplca_pkg::*;

    localparam logic [NODE_W-1:0] c_unassigned_id = NODE_W'(2**NODE_W - 2);
    localparam logic [NODE_W-1:0] c_min_count     = NODE_W'(MIN_NODE_COUNT);
    localparam logic [NODE_W-1:0] c_max_count     = NODE_W'(MAX_NODE_COUNT);
    localparam logic [NODE_W:0]   c_min_count_ext = {1'b0, c_min_count};
    localparam logic [NODE_W:0]   c_max_count_ext = {1'b0, c_max_count};

    // ------------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------------
    dplca_state_t        r_state;
    dplca_state_t        w_next_state;
    logic                w_reenter;
    logic                w_enter;
    logic                r_entry_pending;

    logic [15:0]         r_lfsr;
    logic [RAND_W-1:0]   r_rand_cnt;
    logic [RAND_W-1:0]   w_rand_cnt_nxt;

    logic                r_timer_start;
    logic                w_timer_start_nxt;
    logic                r_aging;
    logic                w_aging_nxt;
    logic [NODE_W-1:0]   r_local_id;
    logic [NODE_W-1:0]   w_local_id_nxt;
    logic [NODE_W-1:0]   r_node_count;
    logic [NODE_W-1:0]   w_node_count_nxt;

    logic [NODE_W-1:0]   w_max_claim;
    logic [NODE_W-1:0]   w_pick_free;
    logic [NODE_W-1:0]   w_last_idx;
    logic [NODE_W:0]     w_reduce_ext;
    logic [NODE_W-1:0]   w_reduce_count;

    logic                w_global_disable;
    logic                w_status_ok;
    logic                w_rx_beacon;
    logic                w_tx_beacon;
    logic                w_claim0;
    logic                w_claim_last;
    logic                w_claim_local;
    logic                w_age_update;

    // ------------------------------------------------------------------------
    // Claim-table priority encoders
    // ------------------------------------------------------------------------
    dplca_claim_scan #(
        .NODE_W      (NODE_W)
    ) u_claim_scan (
        .claim_table (txop_claim_table),
        .node_count  (r_node_count),
        .max_claim   (w_max_claim),
        .pick_free   (w_pick_free)
    );

    // ------------------------------------------------------------------------
    // Decoded conditions
    // ------------------------------------------------------------------------
    assign w_global_disable = !dplca_en || !plca_en;
    assign w_status_ok      = (plca_status == STATUS_OK);
    assign w_rx_beacon      = (rx_cmd == CMD_BEACON);
    assign w_tx_beacon      = (tx_cmd == CMD_BEACON);
    assign w_last_idx       = r_node_count - NODE_W'(1);
    assign w_claim0         = txop_claim_table[0];
    assign w_claim_last     = txop_claim_table[w_last_idx];
    assign w_claim_local    = txop_claim_table[r_local_id];
    assign w_age_update     = dplca_txop_table_upd && dplca_new_age;

    // Shrink target: two above the highest claimed ID, never below the floor
    // and never above the ceiling. One extra bit keeps max_claim+2 exact.
    assign w_reduce_ext = {1'b0, w_max_claim} + (NODE_W+1)'(2);

    always_comb begin
        if (w_reduce_ext < c_min_count_ext) begin
            w_reduce_count = c_min_count;
        end else if (w_reduce_ext > c_max_count_ext) begin
            w_reduce_count = c_max_count;
        end else begin
            w_reduce_count = w_reduce_ext[NODE_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // State register plus registered entry actions and LFSR
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (plca_reset) begin
            r_state         <= ST_DISABLED;
            r_entry_pending <= 1'b1;
            r_lfsr          <= LFSR_SEED;
            r_rand_cnt      <= '0;
            r_timer_start   <= 1'b0;
            r_aging         <= 1'b0;
            r_local_id      <= c_unassigned_id;
            r_node_count    <= c_min_count;
        end else begin
            r_state         <= w_next_state;
            r_entry_pending <= 1'b0;
            r_lfsr          <= lfsr16_next(r_lfsr);
            r_rand_cnt      <= w_rand_cnt_nxt;
            r_timer_start   <= w_timer_start_nxt;
            r_aging         <= w_aging_nxt;
            r_local_id      <= w_local_id_nxt;
            r_node_count    <= w_node_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // The global disable re-enters DISABLED every cycle it is active, so the
    // timer-start pulse keeps being re-issued until the node is enabled; the
    // last pulse therefore lines up with the move to WAIT_BEACON. Reset parks
    // the FSM in DISABLED without its entry action; r_entry_pending makes the
    // first clock out of reset perform that entry.
    always_comb begin
        w_next_state = r_state;
        w_reenter    = 1'b0;
        if (w_global_disable) begin
            w_next_state = ST_DISABLED;
            w_reenter    = 1'b1;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    if (r_entry_pending) begin
                        w_reenter = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT_BEACON;
                    end
                end
                ST_WAIT_BEACON: begin
                    if (w_status_ok) begin
                        w_next_state = ST_LEARNING;
                    end else if (wait_beacon_timer_done && coordinator_role_allowed) begin
                        w_next_state = ST_RANDOM_WAIT;
                    end else if (wait_beacon_timer_done) begin
                        w_next_state = ST_DISABLED;
                    end
                end
                ST_RANDOM_WAIT: begin
                    if (w_status_ok || w_rx_beacon) begin
                        w_next_state = ST_LEARNING;
                    end else if (r_rand_cnt == '0) begin
                        w_next_state = ST_COORDINATOR;
                    end
                end
                ST_COORDINATOR: begin
                    if ((dplca_txop_table_upd && w_claim0) || w_rx_beacon) begin
                        w_next_state = ST_LEARNING;
                    end else if (w_age_update && !w_claim0 && w_claim_last &&
                                 (r_node_count < c_max_count)) begin
                        w_next_state = ST_INCREASE_NODE_COUNT;
                    end else if (w_age_update && !w_claim0 && !w_claim_last &&
                                 (r_node_count > c_min_count)) begin
                        w_next_state = ST_REDUCE_NODE_COUNT;
                    end else if (w_tx_beacon) begin
                        w_next_state = ST_LOOPBACK_TX;
                    end
                end
                ST_REDUCE_NODE_COUNT, ST_INCREASE_NODE_COUNT: begin
                    if (!dplca_new_age) begin
                        w_next_state = ST_COORDINATOR;
                    end
                end
                ST_LOOPBACK_TX: begin
                    if (w_rx_beacon) begin
                        w_next_state = ST_LOOPBACK_RX;
                    end
                end
                ST_LOOPBACK_RX: begin
                    if (!w_rx_beacon) begin
                        w_next_state = ST_COORDINATOR;
                    end
                end
                ST_LEARNING: begin
                    if (!w_status_ok) begin
                        w_next_state = ST_DISABLED;
                    end else if (w_age_update) begin
                        w_next_state = ST_FOLLOWER;
                    end
                end
                ST_FOLLOWER: begin
                    if (!w_status_ok) begin
                        w_next_state = ST_DISABLED;
                    end else if (dplca_txop_table_upd &&
                                 (w_claim_local ||
                                  ((dplca_txop_id == '0) && (dplca_txop_node_count <= r_local_id)) ||
                                  (dplca_new_age && (r_local_id > w_max_claim)))) begin
                        // Our ID collides or has aged out: pick a new one.
                        w_reenter = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_DISABLED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Entry actions, applied on the transition edge
    // ------------------------------------------------------------------------
    assign w_enter = (w_next_state != r_state) || w_reenter;

    always_comb begin
        w_timer_start_nxt = 1'b0;
        w_aging_nxt       = r_aging;
        w_local_id_nxt    = r_local_id;
        w_node_count_nxt  = r_node_count;
        w_rand_cnt_nxt    = r_rand_cnt;
        if (w_enter) begin
            case (w_next_state)
                ST_DISABLED: begin
                    w_timer_start_nxt = 1'b1;
                    w_aging_nxt       = 1'b0;
                end
                ST_WAIT_BEACON: begin
                    w_local_id_nxt   = c_unassigned_id;
                    w_node_count_nxt = c_min_count;
                end
                ST_RANDOM_WAIT: begin
                    w_rand_cnt_nxt = r_lfsr[RAND_W-1:0];
                end
                ST_COORDINATOR: begin
                    w_local_id_nxt = '0;
                    w_aging_nxt    = 1'b1;
                end
                ST_REDUCE_NODE_COUNT: begin
                    w_node_count_nxt = w_reduce_count;
                end
                ST_INCREASE_NODE_COUNT: begin
                    w_node_count_nxt = r_node_count + NODE_W'(1);
                end
                ST_LEARNING: begin
                    w_local_id_nxt = c_unassigned_id;
                    w_aging_nxt    = 1'b1;
                end
                ST_FOLLOWER: begin
                    w_local_id_nxt = w_pick_free;
                end
                default: begin
                end
            endcase
        end else if (r_state == ST_RANDOM_WAIT) begin
            // Staying in RANDOM_WAIT implies the count is non-zero.
            w_rand_cnt_nxt = r_rand_cnt - RAND_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wait_beacon_timer_start = r_timer_start;
    assign dplca_aging             = r_aging;
    assign local_nodeID            = r_local_id;
    assign plca_node_count         = r_node_count;
    assign mod_state               = r_state;

endmodule : dplca_node_ctrl
`default_nettype wire

// File: tb/tb_dplca_node_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dplca_node_ctrl
// Description : Directed self-checking bench for dplca_node_ctrl. Inputs are
//               driven just after the falling edge and outputs are checked at
//               the following falling edge, one rising edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dplca_node_ctrl;

    import dplca_pkg::*;

    logic         clk;
    logic         plca_reset;
    logic         dplca_en;
    logic         plca_en;
    logic         wait_beacon_timer_done;
    logic         coordinator_role_allowed;
    logic         plca_status;
    logic [1:0]   rx_cmd;
    logic [1:0]   tx_cmd;
    logic         dplca_txop_table_upd;
    logic         dplca_new_age;
    logic [7:0]   dplca_txop_id;
    logic [7:0]   dplca_txop_node_count;
    logic [255:0] txop_claim_table;
    logic         wait_beacon_timer_start;
    logic         dplca_aging;
    logic [7:0]   local_nodeID;
    logic [7:0]   plca_node_count;
    logic [3:0]   mod_state;

    int           vectors;
    int           miscompares;
    logic [15:0]  m_lfsr;
    logic         found;
    int           rw_cycles;

    dplca_node_ctrl dut (
        .clk                      (clk),
        .plca_reset               (plca_reset),
        .dplca_en                 (dplca_en),
        .plca_en                  (plca_en),
        .wait_beacon_timer_done   (wait_beacon_timer_done),
        .coordinator_role_allowed (coordinator_role_allowed),
        .plca_status              (plca_status),
        .rx_cmd                   (rx_cmd),
        .tx_cmd                   (tx_cmd),
        .dplca_txop_table_upd     (dplca_txop_table_upd),
        .dplca_new_age            (dplca_new_age),
        .dplca_txop_id            (dplca_txop_id),
        .dplca_txop_node_count    (dplca_txop_node_count),
        .txop_claim_table         (txop_claim_table),
        .wait_beacon_timer_start  (wait_beacon_timer_start),
        .dplca_aging              (dplca_aging),
        .local_nodeID             (local_nodeID),
        .plca_node_count          (plca_node_count),
        .mod_state                (mod_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, seeded on reset.
    always @(posedge clk) begin
        if (plca_reset) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] exp);
        chk(tag, 32'(mod_state), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors                  = 0;
        miscompares              = 0;
        plca_reset               = 1'b1;
        dplca_en                 = 1'b1;
        plca_en                  = 1'b1;
        wait_beacon_timer_done   = 1'b0;
        coordinator_role_allowed = 1'b1;
        plca_status              = STATUS_FAIL;
        rx_cmd                   = CMD_NONE;
        tx_cmd                   = CMD_NONE;
        dplca_txop_table_upd     = 1'b0;
        dplca_new_age            = 1'b0;
        dplca_txop_id            = 8'd1;
        dplca_txop_node_count    = 8'd0;
        txop_claim_table         = '0;

        // ---- Reset state ----
        repeat (3) tick();
        chk_state("rst_state", ST_DISABLED);
        chk("rst_aging", 32'(dplca_aging), 32'd0);
        chk("rst_local", 32'(local_nodeID), 32'd254);
        chk("rst_count", 32'(plca_node_count), 32'd8);
        chk("rst_start", 32'(wait_beacon_timer_start), 32'd0);

        // ---- Out of reset: DISABLED with start pulse, then WAIT_BEACON ----
        plca_reset = 1'b0;
        tick();
        chk_state("c1_state", ST_DISABLED);
        chk("c1_start", 32'(wait_beacon_timer_start), 32'd1);
        tick();
        chk_state("c2_state", ST_WAIT_BEACON);
        chk("c2_local", 32'(local_nodeID), 32'd254);
        chk("c2_count", 32'(plca_node_count), 32'd8);
        chk("c2_start", 32'(wait_beacon_timer_start), 32'd0);

        // ---- Timer expiry with LFSR low nibble 5: 6 cycles of RANDOM_WAIT ----
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_lfsr[3:0] == 4'd5) found = 1'b1;
            else tick();
        end
        chk("lfsr_nibble5_reached", 32'(found), 32'd1);
        chk_state("wb_hold", ST_WAIT_BEACON);
        wait_beacon_timer_done = 1'b1;
        tick();
        wait_beacon_timer_done = 1'b0;
        chk_state("rw_entry", ST_RANDOM_WAIT);
        rw_cycles = 0;
        while (mod_state == ST_RANDOM_WAIT && rw_cycles < 40) begin
            rw_cycles++;
            tick();
        end
        chk("rw_cycles", 32'(rw_cycles), 32'd6);
        chk_state("coord_state", ST_COORDINATOR);
        chk("coord_local", 32'(local_nodeID), 32'd0);
        chk("coord_aging", 32'(dplca_aging), 32'd1);

        // ---- COMMIT on tx is not a loopback trigger ----
        tx_cmd = CMD_COMMIT;
        tick();
        chk_state("tx_commit_hold", ST_COORDINATOR);

        // ---- Loopback ----
        tx_cmd = CMD_BEACON;
        tick();
        chk_state("lb_tx", ST_LOOPBACK_TX);
        tx_cmd = CMD_NONE;
        rx_cmd = CMD_BEACON;
        tick();
        chk_state("lb_rx", ST_LOOPBACK_RX);
        rx_cmd = CMD_NONE;
        tick();
        chk_state("lb_back", ST_COORDINATOR);

        // ---- Grow node count 8 -> 20 (last slot claimed, slot 0 free) ----
        for (int n = 8; n < 20; n++) begin
            txop_claim_table        = '0;
            txop_claim_table[n - 1] = 1'b1;
            dplca_txop_table_upd    = 1'b1;
            dplca_new_age           = 1'b1;
            tick();
            chk_state("inc_state", ST_INCREASE_NODE_COUNT);
            chk("inc_count", 32'(plca_node_count), 32'(n + 1));
            dplca_txop_table_upd = 1'b0;
            dplca_new_age        = 1'b0;
            tick();
            chk_state("inc_return", ST_COORDINATOR);
        end

        // ---- Reduce: N=20, max claim 9, slot 19 free -> N=11 ----
        txop_claim_table     = '0;
        txop_claim_table[9]  = 1'b1;
        dplca_txop_table_upd = 1'b1;
        dplca_new_age        = 1'b1;
        tick();
        chk_state("red9_state", ST_REDUCE_NODE_COUNT);
        chk("red9_count", 32'(plca_node_count), 32'd11);
        dplca_txop_table_upd = 1'b0;
        dplca_new_age        = 1'b0;
        tick();
        chk_state("red9_return", ST_COORDINATOR);

        // ---- Reduce: N=11, max claim 5, slot 10 free -> clamped to 8 ----
        txop_claim_table     = '0;
        txop_claim_table[5]  = 1'b1;
        dplca_txop_table_upd = 1'b1;
        dplca_new_age        = 1'b1;
        tick();
        chk_state("red5_state", ST_REDUCE_NODE_COUNT);
        chk("red5_count", 32'(plca_node_count), 32'd8);
        dplca_txop_table_upd = 1'b0;
        dplca_new_age        = 1'b0;
        tick();
        chk_state("red5_return", ST_COORDINATOR);

        // ---- At the floor N=8 no further reduction ----
        txop_claim_table     = '0;
        txop_claim_table[3]  = 1'b1;
        dplca_txop_table_upd = 1'b1;
        dplca_new_age        = 1'b1;
        tick();
        chk_state("floor_hold", ST_COORDINATOR);
        chk("floor_count", 32'(plca_node_count), 32'd8);

        // ---- Slot 0 claimed by someone else -> LEARNING ----
        txop_claim_table     = '0;
        txop_claim_table[0]  = 1'b1;
        dplca_new_age        = 1'b0;
        plca_status          = STATUS_OK;
        tick();
        chk_state("learn_state", ST_LEARNING);
        chk("learn_local", 32'(local_nodeID), 32'd254);
        chk("learn_aging", 32'(dplca_aging), 32'd1);

        // ---- LEARNING -> FOLLOWER picking ID 3 (1,2 claimed) ----
        txop_claim_table     = 256'h6;
        dplca_new_age        = 1'b1;
        tick();
        chk_state("fol_state", ST_FOLLOWER);
        chk("fol_local3", 32'(local_nodeID), 32'd3);

        // ---- Own ID 3 claimed, 1..4 taken -> re-pick 5 ----
        txop_claim_table     = 256'h1E;
        dplca_new_age        = 1'b0;
        tick();
        chk_state("fol_re_state", ST_FOLLOWER);
        chk("fol_local5", 32'(local_nodeID), 32'd5);

        // ---- 1..7 all claimed -> unassigned 254 ----
        txop_claim_table     = 256'hFE;
        tick();
        chk("fol_local254", 32'(local_nodeID), 32'd254);

        // ---- Coordinator TXOP with count <= our ID -> re-pick 2 ----
        txop_claim_table      = 256'h2;
        dplca_txop_id         = 8'd0;
        dplca_txop_node_count = 8'd8;
        tick();
        chk("fol_local2", 32'(local_nodeID), 32'd2);
        dplca_txop_table_upd  = 1'b0;
        dplca_txop_id         = 8'd1;
        tick();
        chk("fol_hold_local", 32'(local_nodeID), 32'd2);

        // ---- Mid-operation reset ----
        plca_reset = 1'b1;
        tick();
        chk_state("mrst_state", ST_DISABLED);
        chk("mrst_local", 32'(local_nodeID), 32'd254);
        chk("mrst_count", 32'(plca_node_count), 32'd8);
        chk("mrst_aging", 32'(dplca_aging), 32'd0);
        chk("mrst_start", 32'(wait_beacon_timer_start), 32'd0);
        plca_reset  = 1'b0;
        plca_status = STATUS_FAIL;
        tick();
        chk("mrst_c1_start", 32'(wait_beacon_timer_start), 32'd1);
        tick();
        chk_state("mrst_c2_state", ST_WAIT_BEACON);

        // ---- OK status in WAIT_BEACON -> LEARNING; then disable ----
        plca_status = STATUS_OK;
        tick();
        chk_state("wb_ok_learn", ST_LEARNING);
        dplca_en = 1'b0;
        tick();
        chk_state("dis_state", ST_DISABLED);
        chk("dis_start", 32'(wait_beacon_timer_start), 32'd1);
        chk("dis_aging", 32'(dplca_aging), 32'd0);
        dplca_en = 1'b1;
        tick();
        chk_state("reenable_wb", ST_WAIT_BEACON);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dplca_node_ctrl
`default_nettype wire

// File: doc/dplca_node_ctrl.md
DPLCA_NODE_CTRL -- requirements
Module: dplca_node_ctrl

Interface
REQ-001 Parameters SHALL be: NODE_W, default 8, node-ID width; MIN_NODE_COUNT, default 8, floor for plca_node_count; MAX_NODE_COUNT, default 2**NODE_W-1, ceiling; RAND_W, default 4, random-wait counter width; LFSR_SEED, default 16'hACE1, non-zero LFSR seed.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock.
- plca_reset  in  1  synchronous, active-high reset.
- dplca_en, plca_en  in  1 each  enables.
- wait_beacon_timer_done  in  1  external timer expired.
- coordinator_role_allowed  in  1  node may become coordinator.
- plca_status  in  1  OK=1, FAIL=0.
- rx_cmd, tx_cmd  in  2 each  BEACON=00, COMMIT=01, NONE=10.
- dplca_txop_table_upd, dplca_new_age  in  1 each  table-update strobe; new aging cycle.
- dplca_txop_id, dplca_txop_node_count  in  NODE_W each  received TXOP fields.
- txop_claim_table  in  2**NODE_W  bit i set = TXOP i claimed.
- wait_beacon_timer_start  out  1  one-cycle start pulse.
- dplca_aging  out  1  aging enable.
- local_nodeID, plca_node_count  out  NODE_W each  current ID and node count.
- mod_state  out  4  FSM state.

Function
REQ-003 The FSM SHALL be fully synchronous: at most one transition per clk; entry actions SHALL be registered on the transition edge, visible the cycle after.
REQ-004 States SHALL be: DISABLED=0, WAIT_BEACON=1, COORDINATOR=2, REDUCE_NODE_COUNT=3, LOOPBACK_TX=4, LOOPBACK_RX=5, LEARNING=6, INCREASE_NODE_COUNT=7, FOLLOWER=8, RANDOM_WAIT=9; codes 10-15 SHALL go to DISABLED next cycle.
REQ-005 A global condition (!dplca_en || !plca_en) SHALL force DISABLED, overriding all transitions.
REQ-006 DISABLED SHALL go to WAIT_BEACON next cycle; entry SHALL pulse wait_beacon_timer_start and clear dplca_aging.
REQ-007 WAIT_BEACON entry SHALL set local_nodeID=2**NODE_W-2 and plca_node_count=MIN_NODE_COUNT.
REQ-008 WAIT_BEACON exit priority: plca_status==OK -> LEARNING; timer_done&&FAIL&&allowed -> RANDOM_WAIT; timer_done&&FAIL&&!allowed -> DISABLED.
REQ-009 RANDOM_WAIT entry SHALL load a countdown with LFSR[RAND_W-1:0]; exits: OK -> LEARNING; rx_cmd==BEACON -> LEARNING; count==0 -> COORDINATOR; otherwise decrement by 1.
REQ-010 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle out of reset.
REQ-011 COORDINATOR entry SHALL set local_nodeID=0 and dplca_aging=1.
REQ-012 COORDINATOR exit priority, where C(i)=txop_claim_table[i] and N=plca_node_count:
- (upd&&C(0)) || rx_cmd==BEACON -> LEARNING.
- upd&&new_age&&!C(0)&&C(N-1)&&N<MAX_NODE_COUNT -> INCREASE_NODE_COUNT.
- upd&&new_age&&!C(0)&&!C(N-1)&&N>MIN_NODE_COUNT -> REDUCE_NODE_COUNT.
- tx_cmd==BEACON -> LOOPBACK_TX.
REQ-013 REDUCE_NODE_COUNT entry SHALL set N=max(MAX_CLAIM+2, MIN_NODE_COUNT), computed NODE_W+1 wide and saturated at MAX_NODE_COUNT; INCREASE_NODE_COUNT entry SHALL set N=N+1; both SHALL return to COORDINATOR when !dplca_new_age.
REQ-014 LOOPBACK_TX SHALL go to LOOPBACK_RX on rx_cmd==BEACON; LOOPBACK_RX SHALL go to COORDINATOR on rx_cmd!=BEACON.
REQ-015 LEARNING entry SHALL set local_nodeID=2**NODE_W-2 and dplca_aging=1; exits: FAIL -> DISABLED; upd&&new_age&&OK -> FOLLOWER.
REQ-016 FOLLOWER entry and re-entry SHALL set local_nodeID=PICK_FREE; exits: FAIL -> DISABLED; upd&&OK&&(C(local)||(txop_id==0&&txop_node_count<=local)||(new_age&&local>MAX_CLAIM)) -> re-enter FOLLOWER.
REQ-017 MAX_CLAIM SHALL be the highest set index of the table (0 if empty); PICK_FREE SHALL be the lowest clear index in 1..N-1, else 2**NODE_W-2 when none is clear.

Reset
REQ-018 On plca_reset (sampled at clk) the block SHALL enter DISABLED with dplca_aging=0, local_nodeID=2**NODE_W-2, plca_node_count=MIN_NODE_COUNT, wait_beacon_timer_start=0, and LFSR=LFSR_SEED; mid-operation reset SHALL abort any state within one cycle.

Structure
REQ-019 The state codes, BEACON/COMMIT/NONE, and OK/FAIL SHALL live in the shared package dplca_pkg.
REQ-020 One sub-module, dplca_claim_scan, SHALL contain the combinational MAX_CLAIM and PICK_FREE priority encoders, parametrised by NODE_W.

Verification
REQ-021 Reset, then enables=1 -> cycle 1 DISABLED with start=1; cycle 2 WAIT_BEACON with local_nodeID=254, N=8.
REQ-022 WAIT_BEACON, timer_done, FAIL, allowed=1, LFSR low nibble 5 -> 6 cycles in RANDOM_WAIT, then COORDINATOR with local_nodeID=0.
REQ-023 COORDINATOR, N=8, table bits {0 clear, 7 set}, upd+new_age -> INCREASE with N=9; new_age=0 -> COORDINATOR.
REQ-024 COORDINATOR, N=20, max claim 5, bit 19 clear, upd+new_age -> REDUCE with N=8 (clamped); with max claim 9 -> N=11.
REQ-025 FOLLOWER, local=3, bit 3 set by update, bits 1,2,4 set -> local_nodeID=5; all 1..N-1 set -> local_nodeID=254.
REQ-026 tx_cmd BEACON -> LOOPBACK_TX; rx BEACON -> LOOPBACK_RX; rx NONE -> COORDINATOR; dplca_en=0 in any state -> DISABLED next cycle.
